// File: rtl/imem_serial_loader.sv
// imem_serial_loader
//   Writer side of the 16x8 instruction memory. Receives a framed program
//   image over an 8N1 serial line (SYNC_BYTE, LEN, LEN data bytes, CSUM) and
//   writes the data bytes into instruction memory from address 0. The core
//   is held until a complete image with a matching checksum is resident.
//
//   Ports:
//     slow_clk    sole clock, rising edge
//     rst_n       asynchronous active-low reset
//     rx          serial line, idles high, LSB first
//     imem_we     one-cycle instruction-memory write strobe
//     imem_addr   write address (holds LEN mod 2**ADDR_W after a load)
//     imem_wdata  write data
//     core_hold   high: core must not fetch or advance pc
//     load_done   level: a valid image is resident
//     err         level, sticky: last frame failed
//
//   Optional macro LOADER_TIMEOUT_EN: inter-byte timeout of TIMEOUT_CYC cycles
//   while a frame is in progress (LEN/DATA/CSUM) sends the FSM to ERR.
module imem_serial_loader #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          DEPTH        = 16,
  parameter int          ADDR_W       = 4,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          TIMEOUT_CYC  = 4096
) (
  input  logic              slow_clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              err
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int LEN_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [8:0]       DEPTH_9 = 9'(DEPTH);

  // ---------------- rx synchroniser + edge detect ----------------
  logic rx_m, rx_s, rx_d;
  always_ff @(posedge slow_clk or negedge rst_n)
    if (!rst_n) {rx_m, rx_s, rx_d} <= 3'b111;
    else        {rx_m, rx_s, rx_d} <= {rx, rx_m, rx_s};

  logic start_edge;
  assign start_edge = rx_d & ~rx_s;

  // ---------------- UART receiver ----------------
  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} u_state_t;
  u_state_t         u_state, u_state_n;
  logic [CNT_W-1:0] u_cnt, u_cnt_n;
  logic [2:0]       u_bit, u_bit_n;
  logic [7:0]       u_shift, u_shift_n;
  logic             byte_valid, byte_valid_n, frame_err, frame_err_n;

  always_ff @(posedge slow_clk or negedge rst_n)
    if (!rst_n) begin
      u_state <= U_IDLE; u_cnt <= '0; u_bit <= '0; u_shift <= '0;
      byte_valid <= 1'b0; frame_err <= 1'b0;
    end else begin
      u_state <= u_state_n; u_cnt <= u_cnt_n; u_bit <= u_bit_n; u_shift <= u_shift_n;
      byte_valid <= byte_valid_n; frame_err <= frame_err_n;
    end

  // u_cnt counts cycles since the last sample point; the first sample is
  // half a bit after the start edge, later ones a full bit apart.
  always_comb begin
    u_state_n    = u_state;
    u_cnt_n      = u_cnt + CNT_W'(1);
    u_bit_n      = u_bit;
    u_shift_n    = u_shift;
    byte_valid_n = 1'b0;
    frame_err_n  = 1'b0;
    case (u_state)
      U_IDLE: begin
        u_cnt_n = '0;
        if (start_edge) u_state_n = U_START;
      end
      U_START: if (u_cnt == HALF_M1) begin
        u_cnt_n   = '0;
        u_bit_n   = '0;
        u_state_n = rx_s ? U_IDLE : U_DATA;   // high here = glitch, drop it
      end
      U_DATA: if (u_cnt == FULL_M1) begin
        u_cnt_n   = '0;
        u_shift_n = {rx_s, u_shift[7:1]};
        u_bit_n   = u_bit + 3'd1;
        if (u_bit == 3'd7) u_state_n = U_STOP;
      end
      U_STOP: if (u_cnt == FULL_M1) begin
        u_state_n = U_IDLE;
        if (rx_s) byte_valid_n = 1'b1;
        else      frame_err_n  = 1'b1;
      end
      default: u_state_n = U_IDLE;
    endcase
  end

  // ---------------- frame FSM ----------------
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
  state_t            state, state_n;
  logic [LEN_W-1:0]  rem, rem_n;
  logic [7:0]        sum, sum_n;
  logic              we_n, hold_n, done_n, err_n;
  logic [ADDR_W-1:0] addr_n;
  logic [7:0]        wdata_n;
  logic              go_err, in_frame, timeout_hit;

  assign in_frame = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);

`ifdef LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_cnt;
  always_ff @(posedge slow_clk or negedge rst_n)
    if (!rst_n)                                          to_cnt <= '0;
    else if (!in_frame || byte_valid || state_n != state) to_cnt <= '0;
    else                                                 to_cnt <= to_cnt + TO_W'(1);
  assign timeout_hit = in_frame && !byte_valid && (to_cnt == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge slow_clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE; rem <= '0; sum <= '0;
      imem_we <= 1'b0; imem_addr <= '0; imem_wdata <= '0;
      core_hold <= 1'b1; load_done <= 1'b0; err <= 1'b0;
    end else begin
      state <= state_n; rem <= rem_n; sum <= sum_n;
      imem_we <= we_n; imem_addr <= addr_n; imem_wdata <= wdata_n;
      core_hold <= hold_n; load_done <= done_n; err <= err_n;
    end

  always_comb begin
    state_n = state;
    rem_n   = rem;
    sum_n   = sum;
    we_n    = 1'b0;
    addr_n  = imem_we ? imem_addr + ADDR_W'(1) : imem_addr;  // advance after each write
    wdata_n = imem_wdata;
    hold_n  = core_hold;
    done_n  = load_done;
    err_n   = err;
    go_err  = timeout_hit;
    case (state)
      S_IDLE, S_DONE, S_ERR:
        if (byte_valid && u_shift == SYNC_BYTE) begin
          state_n = S_LEN; hold_n = 1'b1; done_n = 1'b0; err_n = 1'b0;
        end
      S_LEN:
        if (frame_err) go_err = 1'b1;
        else if (byte_valid) begin
          if (u_shift == 8'h00 || {1'b0, u_shift} > DEPTH_9) go_err = 1'b1;
          else begin
            rem_n = LEN_W'(u_shift); sum_n = '0; addr_n = '0; state_n = S_DATA;
          end
        end
      S_DATA:
        if (frame_err) go_err = 1'b1;
        else if (byte_valid) begin
          we_n = 1'b1; wdata_n = u_shift; sum_n = sum + u_shift; rem_n = rem - LEN_W'(1);
        end else if (imem_we && rem == '0) state_n = S_CSUM;  // leave only after last write
      S_CSUM:
        if (frame_err) go_err = 1'b1;
        else if (byte_valid) begin
          if (u_shift == sum) begin
            state_n = S_DONE; hold_n = 1'b0; done_n = 1'b1;
          end else go_err = 1'b1;
        end
      default: state_n = S_IDLE;
    endcase
    if (go_err) begin
      state_n = S_ERR; err_n = 1'b1; hold_n = 1'b1; done_n = 1'b0;
    end
  end
endmodule
